// File: rtl/pc_stack_seq.sv
// Program-counter sequencer: advances the PC, takes relative/absolute jumps, and
// handles call/return through a small return-address stack under a run/halt FSM.
module pc_stack_seq #(
    parameter int D           = 12,
    parameter int STACK_DEPTH = 4,
    parameter int START_ADDR  = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               stall,
    input  logic                               jump_en,
    input  logic                               jump_abs,
    input  logic                               direction,
    input  logic [D-1:0]                       target,
    input  logic                               call_en,
    input  logic                               ret_en,
    input  logic                               halt,
    output logic [D-1:0]                       prog_ctr,
    output logic                               running,
    output logic                               done,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               fault
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [D-1:0]   START_PC = D'(START_ADDR);
    localparam logic [SPW-1:0] SP_FULL  = SPW'(STACK_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]     state;
    logic [D-1:0]   stack_mem [0:(2**AW)-1];
    logic [D-1:0]   pc_inc;
    logic [D-1:0]   jump_pc;
    logic [D-1:0]   ret_pc;
    logic [SPW-1:0] sp_dec;
    logic           stack_full;
    logic           stack_empty;
    logic           active;
    logic           push;

    // All PC arithmetic wraps naturally at D bits.
    always_comb begin
        pc_inc      = prog_ctr + D'(1);
        jump_pc     = jump_abs ? target : (direction ? prog_ctr + target : prog_ctr - target);
        sp_dec      = sp - SPW'(1);
        ret_pc      = stack_mem[sp_dec[AW-1:0]];
        stack_full  = (sp == SP_FULL);
        stack_empty = (sp == '0);
        active      = (state == S_RUN) && !reset && !start && !halt && !stall;
        push        = active && !ret_en && call_en && !stack_full;
    end

    // Stack entries need no reset: sp alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[sp[AW-1:0]] <= pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            prog_ctr <= '0;
            sp       <= '0;
            fault    <= 1'b0;
        end else if (start) begin
            state    <= S_RUN;
            prog_ctr <= START_PC;
            sp       <= '0;
            fault    <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (halt) begin
                        state <= S_HALTED;
                    end else if (stall) begin
                        state <= S_RUN;
                    end else if (ret_en) begin
                        if (stack_empty) begin
                            fault <= 1'b1;
                            state <= S_HALTED;
                        end else begin
                            prog_ctr <= ret_pc;
                            sp       <= sp_dec;
                        end
                    end else if (call_en) begin
                        // Overflow halts with PC and stack left exactly as they were.
                        if (stack_full) begin
                            fault <= 1'b1;
                            state <= S_HALTED;
                        end else begin
                            prog_ctr <= jump_pc;
                            sp       <= sp + SPW'(1);
                        end
                    end else if (jump_en) begin
                        prog_ctr <= jump_pc;
                    end else begin
                        prog_ctr <= pc_inc;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    assign running = (state == S_RUN);
    assign done    = (state == S_HALTED);

endmodule

// File: tb/tb_pc_stack_seq.sv
// Bench for pc_stack_seq: table-driven scenarios feeding an expected-status queue,
// plus a randomised jump sequence checked against bench-computed PC values.
module tb_pc_stack_seq;

    localparam int D     = 12;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH + 1);
    localparam int SW    = D + 3 + SPW;

    localparam int NOP = 0, START = 1, STALL = 2, JP = 3, JM = 4, JA = 5, CALL = 6;
    localparam int RET = 7, HALT = 8, STALL_J = 9, HALT_CALL = 10, RESET = 11;
    localparam int RESET_START = 12, CALL_RET = 13, CALL_RELP = 14;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           stall = 1'b0;
    logic           jump_en = 1'b0;
    logic           jump_abs = 1'b0;
    logic           direction = 1'b0;
    logic [D-1:0]   target = '0;
    logic           call_en = 1'b0;
    logic           ret_en = 1'b0;
    logic           halt = 1'b0;
    logic [D-1:0]   prog_ctr;
    logic           running;
    logic           done;
    logic [SPW-1:0] sp;
    logic           fault;
    logic [SW-1:0]  status;

    int n_checks = 0;
    int n_fail   = 0;
    logic [SW-1:0] exp_q[$];

    pc_stack_seq #(.D(D), .STACK_DEPTH(DEPTH), .START_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .jump_en(jump_en), .jump_abs(jump_abs), .direction(direction), .target(target),
        .call_en(call_en), .ret_en(ret_en), .halt(halt),
        .prog_ctr(prog_ctr), .running(running), .done(done), .sp(sp), .fault(fault)
    );

    always #5 clk = ~clk;

    assign status = {prog_ctr, running, done, sp, fault};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [SW-1:0] st(input int pc, input logic r, input logic d,
                                         input int s, input logic f);
        logic [D-1:0]   pcv;
        logic [SPW-1:0] spv;
        pcv = pc[D-1:0];
        spv = s[SPW-1:0];
        return {pcv, r, d, spv, f};
    endfunction

    task automatic drive(input int k, input int t);
        reset = 1'b0; start = 1'b0; stall = 1'b0; jump_en = 1'b0; jump_abs = 1'b0;
        direction = 1'b0; call_en = 1'b0; ret_en = 1'b0; halt = 1'b0;
        target = t[D-1:0];
        case (k)
            START:       start = 1'b1;
            STALL:       stall = 1'b1;
            JP:          begin jump_en = 1'b1; direction = 1'b1; end
            JM:          jump_en = 1'b1;
            JA:          begin jump_en = 1'b1; jump_abs = 1'b1; end
            CALL:        begin call_en = 1'b1; jump_abs = 1'b1; end
            RET:         ret_en = 1'b1;
            HALT:        halt = 1'b1;
            STALL_J:     begin stall = 1'b1; jump_en = 1'b1; jump_abs = 1'b1; end
            HALT_CALL:   begin halt = 1'b1; call_en = 1'b1; jump_abs = 1'b1; end
            RESET:       reset = 1'b1;
            RESET_START: begin reset = 1'b1; start = 1'b1; end
            CALL_RET:    begin call_en = 1'b1; ret_en = 1'b1; jump_abs = 1'b1; end
            CALL_RELP:   begin call_en = 1'b1; jump_en = 1'b1; direction = 1'b1; end
            default:     ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int ops[$];
        int tg[$];
        logic [SW-1:0] ex[$];
        logic [SW-1:0] want;
        ops = '{RESET, NOP, NOP, START, RESET};
        tg  = '{0, 0, 0, 0, 0};
        ex  = '{st(0,0,0,0,0), st(0,0,0,0,0), st(0,0,0,0,0), st(0,1,0,0,0), st(0,0,0,0,0)};
        for (int i = 0; i < ops.size(); i++) begin
            drive(ops[i], tg[i]);
            exp_q.push_back(ex[i]);
            tick();
            want = exp_q.pop_front();
            n_checks++;
            if (status !== want) begin
                n_fail++;
                $display("FAIL reset[%0d]: got {pc,run,done,sp,fault}=%h expected %h", i, status, want);
            end
        end
    endtask

    task automatic test_increment();
        logic [SW-1:0] want;
        drive(START, 0);
        exp_q.push_back(st(0,1,0,0,0));
        tick();
        for (int i = 1; i <= 6; i++) begin
            want = exp_q.pop_front();
            n_checks++;
            if (status !== want) begin
                n_fail++;
                $display("FAIL increment[%0d]: got {pc,run,done,sp,fault}=%h expected %h", i, status, want);
            end
            if (i < 6) begin
                drive(NOP, 0);
                exp_q.push_back(st(i,1,0,0,0));
                tick();
            end
        end
    endtask

    task automatic test_jumps();
        int ops[$];
        int tg[$];
        logic [SW-1:0] ex[$];
        logic [SW-1:0] want;
        ops = '{START, JA, JP, JM, JA};
        tg  = '{0, 10, 6, 20, 'h123};
        ex  = '{st(0,1,0,0,0), st(10,1,0,0,0), st(16,1,0,0,0), st(4092,1,0,0,0), st('h123,1,0,0,0)};
        for (int i = 0; i < ops.size(); i++) begin
            drive(ops[i], tg[i]);
            exp_q.push_back(ex[i]);
            tick();
            want = exp_q.pop_front();
            n_checks++;
            if (status !== want) begin
                n_fail++;
                $display("FAIL jumps[%0d]: got {pc,run,done,sp,fault}=%h expected %h", i, status, want);
            end
        end
    endtask

    task automatic test_call_ret();
        int ops[$];
        int tg[$];
        logic [SW-1:0] ex[$];
        logic [SW-1:0] want;
        ops = '{START, JA, CALL, NOP, NOP, NOP, RET, CALL_RELP, RET, CALL, CALL_RET};
        tg  = '{0, 20, 100, 0, 0, 0, 0, 5, 0, 100, 200};
        ex  = '{st(0,1,0,0,0), st(20,1,0,0,0), st(100,1,0,1,0), st(101,1,0,1,0),
                st(102,1,0,1,0), st(103,1,0,1,0), st(21,1,0,0,0), st(26,1,0,1,0),
                st(22,1,0,0,0), st(100,1,0,1,0), st(23,1,0,0,0)};
        for (int i = 0; i < ops.size(); i++) begin
            drive(ops[i], tg[i]);
            exp_q.push_back(ex[i]);
            tick();
            want = exp_q.pop_front();
            n_checks++;
            if (status !== want) begin
                n_fail++;
                $display("FAIL call_ret[%0d]: got {pc,run,done,sp,fault}=%h expected %h", i, status, want);
            end
        end
    endtask

    task automatic test_stack_limits();
        int ops[$];
        int tg[$];
        logic [SW-1:0] ex[$];
        logic [SW-1:0] want;
        ops = '{START, CALL, CALL, CALL, CALL, CALL, NOP, START, CALL, CALL, RET, RET, RET,
                START, RET};
        tg  = '{0, 100, 200, 300, 400, 500, 0, 0, 100, 200, 0, 0, 0, 0, 0};
        ex  = '{st(0,1,0,0,0), st(100,1,0,1,0), st(200,1,0,2,0), st(300,1,0,3,0),
                st(400,1,0,4,0), st(400,0,1,4,1), st(400,0,1,4,1), st(0,1,0,0,0),
                st(100,1,0,1,0), st(200,1,0,2,0), st(101,1,0,1,0), st(1,1,0,0,0),
                st(1,0,1,0,1), st(0,1,0,0,0), st(0,0,1,0,1)};
        for (int i = 0; i < ops.size(); i++) begin
            drive(ops[i], tg[i]);
            exp_q.push_back(ex[i]);
            tick();
            want = exp_q.pop_front();
            n_checks++;
            if (status !== want) begin
                n_fail++;
                $display("FAIL stack_limits[%0d]: got {pc,run,done,sp,fault}=%h expected %h", i, status, want);
            end
        end
    endtask

    task automatic test_stall_halt_wrap();
        int ops[$];
        int tg[$];
        logic [SW-1:0] ex[$];
        logic [SW-1:0] want;
        ops = '{START, NOP, STALL_J, STALL, CALL, HALT_CALL, NOP, START, JA, NOP, JA, CALL,
                RET, JA, JP, JM, HALT};
        tg  = '{0, 0, 'h50, 0, 100, 200, 0, 0, 'hFFF, 0, 'hFFF, 5, 0, 'hFFE, 3, 2, 0};
        ex  = '{st(0,1,0,0,0), st(1,1,0,0,0), st(1,1,0,0,0), st(1,1,0,0,0),
                st(100,1,0,1,0), st(100,0,1,1,0), st(100,0,1,1,0), st(0,1,0,0,0),
                st('hFFF,1,0,0,0), st(0,1,0,0,0), st('hFFF,1,0,0,0), st(5,1,0,1,0),
                st(0,1,0,0,0), st('hFFE,1,0,0,0), st(1,1,0,0,0), st('hFFF,1,0,0,0),
                st('hFFF,0,1,0,0)};
        for (int i = 0; i < ops.size(); i++) begin
            drive(ops[i], tg[i]);
            exp_q.push_back(ex[i]);
            tick();
            want = exp_q.pop_front();
            n_checks++;
            if (status !== want) begin
                n_fail++;
                $display("FAIL stall_halt_wrap[%0d]: got {pc,run,done,sp,fault}=%h expected %h", i, status, want);
            end
        end
    endtask

    task automatic test_restart();
        int ops[$];
        int tg[$];
        logic [SW-1:0] ex[$];
        logic [SW-1:0] want;
        ops = '{START, CALL, CALL, CALL, START, RET, START, CALL, RESET_START, NOP, START};
        tg  = '{0, 100, 200, 300, 0, 0, 0, 100, 0, 0, 0};
        ex  = '{st(0,1,0,0,0), st(100,1,0,1,0), st(200,1,0,2,0), st(300,1,0,3,0),
                st(0,1,0,0,0), st(0,0,1,0,1), st(0,1,0,0,0), st(100,1,0,1,0),
                st(0,0,0,0,0), st(0,0,0,0,0), st(0,1,0,0,0)};
        for (int i = 0; i < ops.size(); i++) begin
            drive(ops[i], tg[i]);
            exp_q.push_back(ex[i]);
            tick();
            want = exp_q.pop_front();
            n_checks++;
            if (status !== want) begin
                n_fail++;
                $display("FAIL restart[%0d]: got {pc,run,done,sp,fault}=%h expected %h", i, status, want);
            end
        end
    endtask

    task automatic test_random_jumps();
        logic [D-1:0]  pc_m;
        logic [D-1:0]  t;
        logic [SW-1:0] want;
        int            k;
        drive(START, 0);
        tick();
        pc_m = '0;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 3);
            t = D'($urandom_range(0, 4095));
            case (k)
                0:       begin drive(NOP, int'(t)); pc_m = pc_m + D'(1); end
                1:       begin drive(JP, int'(t));  pc_m = pc_m + t; end
                2:       begin drive(JM, int'(t));  pc_m = pc_m - t; end
                default: begin drive(JA, int'(t));  pc_m = t; end
            endcase
            exp_q.push_back({pc_m, 1'b1, 1'b0, {SPW{1'b0}}, 1'b0});
            tick();
            want = exp_q.pop_front();
            n_checks++;
            if (status !== want) begin
                n_fail++;
                $display("FAIL random_jumps[%0d]: got {pc,run,done,sp,fault}=%h expected %h", i, status, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_jumps();
        test_call_ret();
        test_stack_limits();
        test_stall_halt_wrap();
        test_restart();
        test_random_jumps();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
